// File: rtl/pc_call_seq_pkg.sv
// pc_call_seq_pkg: shared state encoding, defaults and depth-width helper for the PC call sequencer
package pc_call_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RET_WAIT, DONE} state_e;
  localparam int START_ADDR_DEFAULT = 0;
  function automatic int depth_width(input int entries);
    return $clog2(entries + 1);
  endfunction
endpackage

// File: rtl/pc_call_sequencer_ras_depth_tracker.sv
// ras_depth_tracker: saturating occupancy counter for the return-address stack
module ras_depth_tracker
  import pc_call_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic push_req_i,
  input  logic pop_req_i,
  output logic push_ok_o,
  output logic pop_ok_o,
  output logic overflow_o,
  output logic underflow_o
);
  localparam int W = depth_width(STACK_DEPTH);
  logic [W-1:0] depth_q, depth_d;
  always_comb begin
    push_ok_o   = depth_q < W'(STACK_DEPTH);
    pop_ok_o    = depth_q != '0;
    overflow_o  = push_req_i && !push_ok_o;
    underflow_o = pop_req_i && !pop_ok_o;
    depth_d     = clear_i ? '0 :
                  (push_req_i && push_ok_o) ? depth_q + W'(1) :
                  (pop_req_i && pop_ok_o) ? depth_q - W'(1) : depth_q;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) depth_q <= '0;
    else depth_q <= depth_d;
endmodule

// File: rtl/pc_call_sequencer.sv
// pc_call_sequencer: fetch PC sequencer driving a return-address stack (call/ret/branch/halt)
// Optional PC_SEQ_TRACE_EN builds a retired-instruction counter on insn_count_o.
module pc_call_sequencer
  import pc_call_seq_pkg::*;
#(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 8,
  parameter int START_ADDR  = START_ADDR_DEFAULT
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         call_en_i,
  input  logic         ret_en_i,
  input  logic         branch_en_i,
  input  logic         halt_en_i,
  input  logic [D-1:0] target_i,
  input  logic [D-1:0] ras_target_i,
  output logic [D-1:0] pc_o,
  output logic [D-1:0] ras_addr_o,
  output logic [D-1:0] ras_target_in_o,
  output logic         ras_call_o,
  output logic         ras_ret_o,
  output logic         stall_o,
  output logic         done_o,
  output logic         stack_fault_o,
  output logic [15:0]  insn_count_o
);
  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  state_e state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic fault_q, fault_d;
  logic run, halt, ret_req, call_req, br_req, accept, restart;
  logic push_ok, pop_ok, ovf, unf;
  // strict strobe priority: halt > ret > call > branch
  always_comb begin
    run      = state_q == RUN;
    halt     = run && halt_en_i;
    ret_req  = run && !halt_en_i && ret_en_i;
    call_req = run && !halt_en_i && !ret_en_i && call_en_i;
    br_req   = run && !halt_en_i && !ret_en_i && !call_en_i && branch_en_i;
    accept   = start_i && (state_q == IDLE || state_q == DONE);
    restart  = start_i && state_q == DONE;
  end
  ras_depth_tracker #(.STACK_DEPTH(STACK_DEPTH)) u_depth (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (restart),
    .push_req_i (call_req),
    .pop_req_i  (ret_req),
    .push_ok_o  (push_ok),
    .pop_ok_o   (pop_ok),
    .overflow_o (ovf),
    .underflow_o(unf)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  always_comb begin
    state_d = accept ? RUN :
              state_q == RET_WAIT ? RUN :
              !run ? state_q :
              halt ? DONE :
              (ret_req && pop_ok) ? RET_WAIT : RUN;
    pc_d    = restart ? START_PC :
              state_q == RET_WAIT ? ras_target_i :
              (call_req || br_req) ? target_i :
              (run && !halt && !(ret_req && pop_ok)) ? pc_q + D'(1) : pc_q;
    fault_d = restart ? 1'b0 : fault_q | ovf | unf;
  end
  always_comb begin
    pc_o            = pc_q;
    ras_addr_o      = pc_q;
    ras_target_in_o = target_i;
    ras_call_o      = call_req && push_ok;
    ras_ret_o       = ret_req && pop_ok;
    stall_o         = state_q == RET_WAIT;
    done_o          = state_q == DONE;
    stack_fault_o   = fault_q;
  end
`ifdef PC_SEQ_TRACE_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (run && state_d == RUN) cnt_q <= cnt_q + 16'd1;
  assign insn_count_o = cnt_q;
`else
  assign insn_count_o = '0;
`endif
endmodule

// File: doc/pc_call_sequencer.md
Name: pc_call_sequencer

Overview:
Fetch-side program-counter sequencer that drives the return-address-stack interface: it issues push (call) and pop (ret) requests and consumes the popped return target.
- Owns the PC and resolves call, return, branch and halt from decoder strobes.
- Tracks stack depth to flag overflow and underflow.
- Sits between the instruction decoder and the return-address stack; its pc output feeds instruction ROM and the stack's addr input.

Parameters:
D, 12, PC / address width
STACK_DEPTH, 8, entries in the attached return-address stack
START_ADDR, 0, PC value after reset and after restart

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  pulse: leave IDLE or DONE, begin at START_ADDR
call_en  input  1  decoder: current instruction is a call
ret_en  input  1  decoder: current instruction is a return
branch_en  input  1  decoder: taken jump
halt_en  input  1  decoder: halt instruction
target  input  D  decoded jump/call target
ras_target  input  D  return target from stack, valid the cycle after ras_ret
pc  output  D  current program counter
ras_addr  output  D  address of the call instruction (= pc), to stack
ras_target_in  output  D  pass-through of target, to stack
ras_call  output  1  push request, combinational, sampled by stack on same edge
ras_ret  output  1  pop request, combinational
stall  output  1  high in RET_WAIT; decoder must hold or ignore its instruction
done  output  1  high in DONE
stack_fault  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (asynchronous, active-high) forces the following; reset mid-operation abandons any pending return immediately.
  - state=IDLE, pc=START_ADDR, depth=0.
  - stack_fault, done, stall = 0.
  - ras_call and ras_ret = 0.
- FSM states: IDLE, RUN, RET_WAIT, DONE.
- IDLE: pc held. start -> RUN. All other inputs ignored.
- RUN: one decision per cycle, using this priority:
  - halt_en: go to DONE, pc held.
  - ret_en with depth>0: assert ras_ret, depth-1, go to RET_WAIT, pc held.
  - ret_en with depth==0 (underflow): no ras_ret, stack_fault<=1, pc<=pc+1.
  - call_en with depth<STACK_DEPTH: assert ras_call (ras_addr=pc), depth+1, pc<=target.
  - call_en with depth==STACK_DEPTH (overflow): no ras_call, stack_fault<=1, pc<=target.
  - branch_en: pc<=target.
  - otherwise: pc<=pc+1.
- Simultaneous strobes are resolved strictly by this priority; lower-priority strobes have no effect.
- RET_WAIT: exactly one cycle.
  - stall=1; all decoder strobes ignored; ras_call=ras_ret=0.
  - pc<=ras_target; then -> RUN.
  - Return latency is 2 cycles from ret_en to the new pc.
- DONE: done=1, pc held, strobes ignored.
  - start -> pc<=START_ADDR, depth<=0, stack_fault<=0, -> RUN.
- Arithmetic: pc+1 wraps modulo 2^D (all-ones -> 0, no flag). depth is $clog2(STACK_DEPTH+1) bits, saturating at 0 and STACK_DEPTH.
- ras_addr = pc and ras_target_in = target, continuously. Both are valid whenever ras_call=1.

Optional Feature:
PC_SEQ_TRACE_EN
- Defined: adds output insn_count[15:0].
  - Reset to 0; cleared on start.
  - Increments on every RUN cycle that does not enter DONE or RET_WAIT; RET_WAIT cycles are not counted.
  - Wraps at 16'hFFFF -> 0.
- Undefined: the port is present but tied to 0 and no counter logic is built.

Decomposition:
- Package pc_call_seq_pkg holds:
  - the state enum (IDLE, RUN, RET_WAIT, DONE);
  - a localparam for START_ADDR default;
  - a function computing the depth width from STACK_DEPTH.
- One natural sub-module: ras_depth_tracker. It owns the depth counter and produces push_ok, pop_ok and the overflow/underflow pulses.

Test Plan:
- Reset then start, no strobes for 5 cycles -> pc goes 0,1,2,3,4,5; stall=0; ras_call=ras_ret=0.
- At pc=3, call_en with target=0x40 -> ras_call=1 and ras_addr=3 that cycle; next pc=0x40.
  - Two cycles later ret_en, stack returns ras_target=4 -> ras_ret=1; stall=1 for one cycle; pc=4 on the following cycle.
- 9 nested calls with STACK_DEPTH=8 -> ras_call pulses 8 times; 9th call has no pulse but still jumps; stack_fault=1 and stays set.
- ret_en at depth 0 -> no ras_ret; pc increments by 1; stack_fault=1.
- call_en, ret_en and branch_en in the same cycle at depth 1 -> return wins; call and branch are ignored; depth becomes 0.
- pc=0xFFF sequential -> pc=0x000.
  - Then halt_en -> done=1 and pc frozen.
  - Then assert reset during RET_WAIT -> pc=START_ADDR, state IDLE, stall=0 immediately.
